// File: rtl/sram_test_sequencer.sv
// SRAM exerciser: writes a generated pattern over addresses 0..COUNT-1, then
// reads it back for display and optional comparison against the same pattern.
module sram_test_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned COUNT  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_write,
  input  logic              start_read,
  input  logic              verify_en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_drive,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COUNT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ERR_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DO   = 3'd1,
    WR_SET  = 3'd2,
    RD_ADDR = 3'd3,
    RD_CAP  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   seed_q;
  logic                verify_q;

  // Pattern word for address index i, wrapping modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] i);
    logic [DATA_W-1:0] iw;
    iw = DATA_W'(i);
    case (m)
      2'd0:    return s - iw;
      2'd1:    return s + iw;
      2'd2:    return iw;
      default: return ~iw;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mode_q         <= '0;
      seed_q         <= '0;
      verify_q       <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_drive      <= 1'b1;
      mem_read       <= 1'b1;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      err_flag       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          // Read wins when both starts are present.
          if (start_read) begin
            mode_q         <= mode;
            seed_q         <= seed;
            verify_q       <= verify_en;
            mem_addr       <= '0;
            mem_drive      <= 1'b0;
            mem_read       <= 1'b1;
            busy           <= 1'b1;
            err_count      <= '0;
            first_err_addr <= '0;
            err_flag       <= 1'b0;
            state          <= RD_ADDR;
          end else if (start_write) begin
            mode_q    <= mode;
            seed_q    <= seed;
            verify_q  <= verify_en;
            mem_addr  <= '0;
            mem_wdata <= pattern(mode, seed, '0);
            mem_drive <= 1'b1;
            mem_read  <= 1'b0;
            busy      <= 1'b1;
            state     <= WR_DO;
          end
        end
        WR_DO: begin
          mem_read <= 1'b1;
          state    <= WR_SET;
        end
        WR_SET: begin
          if (mem_addr == LAST_ADDR) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_addr  <= mem_addr + ADDR_ONE;
            mem_wdata <= pattern(mode_q, seed_q, mem_addr + ADDR_ONE);
            mem_read  <= 1'b0;
            state     <= WR_DO;
          end
        end
        RD_ADDR: begin
          state <= RD_CAP;
        end
        RD_CAP: begin
          // SRAM data for the address presented in RD_ADDR is valid now.
          rd_data  <= mem_rdata;
          rd_valid <= 1'b1;
          if (verify_q && (mem_rdata != pattern(mode_q, seed_q, mem_addr))) begin
            err_count <= err_count + ERR_ONE;
            err_flag  <= 1'b1;
            if (err_count == '0) begin
              first_err_addr <= mem_addr;
            end
          end
          if (mem_addr == LAST_ADDR) begin
            mem_drive <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            mem_addr <= mem_addr + ADDR_ONE;
            state    <= RD_ADDR;
          end
        end
        DONE: begin
          mem_drive <= 1'b1;
          mem_read  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
